// File: rtl/fast_pkg.sv
// Shared types for the FAST keypoint scheduler:
// keypoint record, frame FSM states and coordinate widths.
package fast_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int S_W = 16;
  localparam int C_W = 10;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [S_W-1:0] score;
  } kp_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    DONE
  } sched_state_e;
endpackage

// File: rtl/fast_kp_fifo.sv
// First-word-fall-through keypoint buffer.
// Output reads as zero while empty.
module fast_kp_fifo
  import fast_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic push,
  input  kp_t  din,
  output logic full,
  input  logic pop,
  output kp_t  dout,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  kp_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW])
    && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/fast_keypoint_scheduler.sv
// Qualifies FAST scores, buffers keypoints and
// drains them per frame under a keypoint budget.
module fast_keypoint_scheduler
  import fast_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int BORDER     = 3,
  parameter int MAX_KP     = 500,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_enable,
  input  logic [15:0]    i_threshold,
  input  logic           i_image_vs,
  input  logic           i_image_hs,
  input  logic           i_image_en,
  input  logic [15:0]    i_image_data,
  output logic           o_kp_valid,
  input  logic           i_kp_ready,
  output logic [X_W-1:0] o_kp_x,
  output logic [Y_W-1:0] o_kp_y,
  output logic [S_W-1:0] o_kp_score,
  output logic [C_W-1:0] o_kp_count,
  output logic           o_overflow,
  output logic           o_frame_done
);
  localparam logic [X_W-1:0] X_LO  = X_W'(BORDER);
  localparam logic [X_W-1:0] X_HI  = X_W'(IMG_W - 1 - BORDER);
  localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LO  = Y_W'(BORDER);
  localparam logic [Y_W-1:0] Y_HI  = Y_W'(IMG_H - 1 - BORDER);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);
  localparam logic [C_W-1:0] MAX_C = C_W'(MAX_KP);

  sched_state_e state, state_n;

  logic vs_q, vs_d, hs_q, hs_d, en_q, enable_q;
  logic [S_W-1:0] data_q, thr_q, thr;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic vs_rise, vs_fall, hs_fall;
  logic frame_start, in_x, in_y, qual;
  logic full, empty;
  kp_t  push_kp, head_kp;

  // vs history resets high so a frame already in
  // progress at reset release is never taken as a start
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_q     <= 1'b1;
      vs_d     <= 1'b1;
      hs_q     <= 1'b0;
      hs_d     <= 1'b0;
      en_q     <= 1'b0;
      enable_q <= 1'b0;
      data_q   <= '0;
      thr_q    <= '0;
    end else begin
      vs_q     <= i_image_vs;
      vs_d     <= vs_q;
      hs_q     <= i_image_hs;
      hs_d     <= hs_q;
      en_q     <= i_image_en;
      enable_q <= i_enable;
      data_q   <= i_image_data;
      thr_q    <= i_threshold;
    end
  end

  assign vs_rise = vs_q && !vs_d;
  assign vs_fall = !vs_q && vs_d;
  assign hs_fall = !hs_q && hs_d;
  assign frame_start = (state == IDLE) && vs_rise && enable_q;

  assign in_x = (x_cnt >= X_LO) && (x_cnt <= X_HI);
  assign in_y = (y_cnt >= Y_LO) && (y_cnt <= Y_HI);
  assign qual = (state == ACTIVE) && en_q && (data_q >= thr)
    && in_x && in_y && (o_kp_count < MAX_C);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (frame_start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (hs_fall) begin
      x_cnt <= '0;
      if (y_cnt != Y_MAX) y_cnt <= y_cnt + 1'b1;
    end else if (en_q && (x_cnt != X_MAX)) begin
      x_cnt <= x_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      thr        <= '0;
      o_kp_count <= '0;
      o_overflow <= 1'b0;
    end else if (frame_start) begin
      thr        <= thr_q;
      o_kp_count <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (qual && !full) o_kp_count <= o_kp_count + 1'b1;
      if (qual && full) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (frame_start) state_n = ACTIVE;
      ACTIVE:  if (vs_fall) state_n = DRAIN;
      DRAIN:   if (empty) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign push_kp = '{x: x_cnt, y: y_cnt, score: data_q};

  fast_kp_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .push   (qual),
    .din    (push_kp),
    .full   (full),
    .pop    (i_kp_ready),
    .dout   (head_kp),
    .empty  (empty)
  );

  assign o_kp_valid   = !empty;
  assign o_kp_x       = head_kp.x;
  assign o_kp_y       = head_kp.y;
  assign o_kp_score   = head_kp.score;
  assign o_frame_done = state == DONE;
endmodule

// File: doc/fast_keypoint_scheduler.md
# fast_keypoint_scheduler

Sits downstream of the FAST score stage and schedules detected keypoints out of the ORB front end. It tracks pixel coordinates from the image stream, qualifies each score against a per-frame threshold and the detector border, and buffers accepted keypoints in a small FIFO. It enforces a per-frame keypoint budget and drains keypoints to the descriptor stage over a valid/ready handshake. A frame-level FSM sequences frame start, drain and frame-done reporting.

## Interface
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- BORDER, 3, pixels excluded on every edge (7x7 window radius)
- MAX_KP, 500, maximum keypoints emitted per frame
- FIFO_DEPTH, 16, keypoint buffer depth (power of 2)
- i_clk  in  1  clock, single domain
- i_rst_n  in  1  asynchronous, active-low reset
- i_enable  in  1  sampled at frame start; 0 means the frame is ignored
- i_threshold  in  16  minimum score, latched at frame start
- i_image_vs  in  1  frame active (high during frame)
- i_image_hs  in  1  line active (high during line)
- i_image_en  in  1  pixel valid
- i_image_data  in  16  FAST score for the current pixel
- o_kp_valid  out  1  keypoint available
- i_kp_ready  in  1  consumer accepts keypoint
- o_kp_x  out  10  column
- o_kp_y  out  9  row
- o_kp_score  out  16  score
- o_kp_count  out  10  keypoints accepted this frame
- o_overflow  out  1  sticky per frame: a qualified keypoint was dropped because the FIFO was full
- o_frame_done  out  1  one-cycle pulse after the frame has been fully drained

## Operation
- Coordinates: x increments on each i_image_en, clears on the falling edge of hs. y increments on each falling edge of hs and clears at frame start. Both saturate at IMG_W-1 and IMG_H-1 respectively.
- A pixel qualifies when all of the following hold: en=1; score >= threshold (unsigned); BORDER <= x <= IMG_W-1-BORDER; BORDER <= y <= IMG_H-1-BORDER; o_kp_count < MAX_KP.
- Qualified pixel with FIFO not full: push {x,y,score} and increment o_kp_count.
- Qualified pixel with FIFO full: drop it and set o_overflow. The full flag is evaluated before any same-cycle pop, so a pop in that cycle does not rescue the push.
- Budget reached: further qualified pixels are silently discarded; o_overflow is not set.
- FSM states:
  - IDLE: on vs rising edge with i_enable=1, latch the threshold, clear o_kp_count, o_overflow and y, then go to ACTIVE. With i_enable=0, stay in IDLE for that frame.
  - ACTIVE: accept keypoints. On vs falling edge, go to DRAIN.
  - DRAIN: no pushes. When the FIFO is empty, go to DONE.
  - DONE: assert o_frame_done for 1 cycle, then go to IDLE.
- A vs rising edge seen in DRAIN or DONE is ignored; that whole frame is skipped.
- Handshake: a transfer occurs when o_kp_valid && i_kp_ready. While valid is high and ready is low, x, y and score hold stable. Valid never drops without a transfer.
- o_kp_count and o_overflow hold their values after DONE until the next accepted frame start.

## Timing
- Reset (async assert, sync deassert by the reset source): state=IDLE, FIFO empty, o_kp_valid=0, o_kp_x=0, o_kp_y=0, o_kp_score=0, o_kp_count=0, o_overflow=0, o_frame_done=0.
- Reset asserted mid-frame: all state is lost. After release the block waits in IDLE for the next vs rise; it never resumes mid-frame.
- Inputs are registered once for edge detection and qualification. A pixel presented before edge k is pushed at edge k+1, and o_kp_valid rises after edge k+1 (FWFT FIFO). Latency is 2 cycles into an empty FIFO.
- Sustained throughput is 1 keypoint per cycle in and 1 per cycle out.
- o_frame_done comes no earlier than 2 cycles after the vs fall, with the FIFO empty.

## Structure
- fast_pkg holds:
  - kp_t struct {x[9:0], y[8:0], score[15:0]}
  - sched_state_e {IDLE, ACTIVE, DRAIN, DONE}
  - coordinate width constants
- Sub-module fast_kp_fifo: synchronous FWFT FIFO of kp_t with the same async active-low reset, and full/empty flags.

## Test plan
- Threshold 100; single pixel at (10,20) with score 150, ready=1 -> one keypoint x=10, y=20, score=150, 2 cycles later; count=1; frame_done after vs fall.
- Scores of 200 at (2,5), (637,5), (10,477) and (3,3) -> only (3,3) is emitted; count=1.
- ready held 0; 20 consecutive qualified pixels -> first 16 buffered, overflow=1, count=16; after ready=1 exactly 16 keypoints drain in order, then frame_done.
- MAX_KP=4; 10 qualified pixels, ready=1 -> 4 keypoints, count=4, overflow=0.
- Toggle ready randomly during a drain -> no duplicates or losses; outputs stable while valid && !ready.
- Assert reset mid-ACTIVE with 5 keypoints in the FIFO -> valid=0 immediately, count=0; the next frame starts clean. Separately, i_enable=0 at a vs rise -> no keypoints and no frame_done for that frame.
